menu_state_ctrl: RTL and testbench

- Upstream neighbour of the OLED screen multiplexer. Produces the 4-bit machine_state that selects which screen's pixel data reaches the display.
- Debounces the five Basys3 push-buttons and runs the home-menu cursor.
- Handles entry into an application screen, stepping between application screens, and long-press escape back to home.
- Valid machine_state codes: 0 (home), 1, 3, 4, 5, 6, 8, 9, 10. Codes 2, 7 and 11–15 are never produced.

---
 rtl/menu_pkg.sv | 49 ++++
 rtl/btn_debounce.sv | 46 ++++
 rtl/menu_state_ctrl.sv | 108 ++++++++++
 tb/tb_menu_state_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Screen codes and app-list helpers shared by the menu controller, the OLED mux and the renderers.
package menu_pkg;

  localparam int NUM_APPS = 8;

  // Button slots used by the controller's debouncer bank
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  typedef enum logic [3:0] {
    ST_HOME  = 4'd0,
    ST_APP1  = 4'd1,
    ST_APP3  = 4'd3,
    ST_APP4  = 4'd4,
    ST_APP5  = 4'd5,
    ST_APP6  = 4'd6,
    ST_APP8  = 4'd8,
    ST_APP9  = 4'd9,
    ST_APP10 = 4'd10
  } screen_e;

  localparam screen_e APP_LIST [NUM_APPS] = '{
    ST_APP1, ST_APP3, ST_APP4, ST_APP5, ST_APP6, ST_APP8, ST_APP9, ST_APP10
  };

  function automatic logic [2:0] code_to_index(input logic [3:0] code);
    case (code)
      4'd3:    return 3'd1;
      4'd4:    return 3'd2;
      4'd5:    return 3'd3;
      4'd6:    return 3'd4;
      4'd8:    return 3'd5;
      4'd9:    return 3'd6;
      4'd10:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_valid_state(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; press pulses once per accepted 0->1 level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/menu_state_ctrl.sv
// Home-menu cursor, app entry/stepping and long-press escape; drives the screen code for the OLED mux.
module menu_state_ctrl
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [3:0] machine_state,
  output logic [2:0] cursor,
  output logic       state_changed
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  logic [4:0]    w_raw;
  logic [4:0]    w_level;
  logic [4:0]    w_press;
  logic          w_levels_unused;
  logic          w_valid;
  logic          w_is_app;
  logic          w_escape;
  logic [2:0]    w_next_idx;
  logic [3:0]    w_state_next;
  logic [2:0]    w_cursor_next;

  logic [3:0]    r_state;
  logic [2:0]    r_cursor;
  logic          r_changed;
  logic [HW-1:0] r_hold_cnt;
  logic          r_hold_lock;

  assign w_raw = {btnR, btnL, btnD, btnU, btnC};

  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (w_raw[gi]),
      .level (w_level[gi]),
      .press (w_press[gi])
    );
  end

  // Only btnL needs its held level; btnL's press pulse has no action.
  assign w_levels_unused = ^{w_level[BTN_R], w_level[BTN_D], w_level[BTN_U],
                             w_level[BTN_C], w_press[BTN_L]};

  assign w_valid    = is_valid_state(r_state);
  assign w_is_app   = w_valid && (r_state != ST_HOME);
  assign w_escape   = w_is_app && w_level[BTN_L] && !r_hold_lock &&
                      (r_hold_cnt == HW'(HOLD_CYCLES - 1));
  assign w_next_idx = code_to_index(r_state) + 3'd1;

  always_comb begin
    w_state_next  = r_state;
    w_cursor_next = r_cursor;
    if (!w_valid) begin
      w_state_next  = ST_HOME;
      w_cursor_next = 3'd0;
    end else if (w_escape) begin
      w_state_next = ST_HOME;
    end else if (!w_is_app) begin
      if (w_press[BTN_C])      w_state_next  = APP_LIST[r_cursor];
      else if (w_press[BTN_U]) w_cursor_next = r_cursor - 3'd1;
      else if (w_press[BTN_D]) w_cursor_next = r_cursor + 3'd1;
    end else if (w_press[BTN_R]) begin
      w_state_next  = APP_LIST[w_next_idx];
      w_cursor_next = w_next_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_HOME;
      r_cursor    <= 3'd0;
      r_changed   <= 1'b0;
      r_hold_cnt  <= '0;
      r_hold_lock <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cursor  <= w_cursor_next;
      r_changed <= (w_state_next != r_state);
      if (!w_level[BTN_L] || !w_is_app)
        r_hold_cnt <= '0;
      else if (r_hold_cnt != HW'(HOLD_CYCLES - 1))
        r_hold_cnt <= r_hold_cnt + HW'(1);
      // Lock survives re-entry into an app so one long press escapes once.
      if (!w_level[BTN_L])
        r_hold_lock <= 1'b0;
      else if (w_escape)
        r_hold_lock <= 1'b1;
    end
  end

  assign machine_state = r_state;
  assign cursor        = r_cursor;
  assign state_changed = r_changed;

endmodule

// File: tb/tb_menu_state_ctrl.sv
// Directed plus randomized bench for menu_state_ctrl against a behavioural menu model.
module tb_menu_state_ctrl;

  localparam int DC = 4;
  localparam int HC = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnC = 1'b0, btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic [3:0] machine_state;
  logic [2:0] cursor;
  logic       state_changed;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] app_codes [8] = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
  logic [3:0] m_state;
  logic [2:0] m_cursor;

  menu_state_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btnC         (btnC),
    .btnU         (btnU),
    .btnD         (btnD),
    .btnL         (btnL),
    .btnR         (btnR),
    .machine_state(machine_state),
    .cursor       (cursor),
    .state_changed(state_changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mask bits: 0=C 1=U 2=D 3=L 4=R
  task automatic set_btns(input logic [4:0] mask);
    btnC = mask[0];
    btnU = mask[1];
    btnD = mask[2];
    btnL = mask[3];
    btnR = mask[4];
  endtask

  task automatic model_press(input logic [4:0] mask);
    int idx;
    if (m_state == 4'd0) begin
      if (mask[0])      m_state  = app_codes[m_cursor];
      else if (mask[1]) m_cursor = 3'((int'(m_cursor) + 7) % 8);
      else if (mask[2]) m_cursor = 3'((int'(m_cursor) + 1) % 8);
    end else if (mask[4]) begin
      idx = 0;
      for (int k = 0; k < 8; k++) if (app_codes[k] == m_state) idx = k;
      idx      = (idx + 1) % 8;
      m_state  = app_codes[idx];
      m_cursor = 3'(idx);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_btns(5'b0);
    repeat (3) tick();
    check("rst_state", machine_state, 0);
    check("rst_cursor", cursor, 0);
    check("rst_changed", state_changed, 0);
    rst_n    = 1'b1;
    m_state  = 4'd0;
    m_cursor = 3'd0;
  endtask

  // Clean press: effect must land exactly 2 sync + DC debounce + 1 edges after the raw rise.
  task automatic press(input logic [4:0] mask);
    logic [3:0] old_s;
    logic [2:0] old_c;
    old_s = m_state;
    old_c = m_cursor;
    set_btns(mask);
    repeat (DC + 2) tick();
    check("pre_state", machine_state, old_s);
    check("pre_cursor", cursor, old_c);
    tick();
    model_press(mask);
    check("post_state", machine_state, m_state);
    check("post_cursor", cursor, m_cursor);
    check("post_changed", state_changed, (m_state != old_s) ? 1 : 0);
    tick();
    check("changed_clear", state_changed, 0);
    set_btns(5'b0);
    repeat (DC + 4) tick();
    $display("press mask=%05b -> state=%0d cursor=%0d", mask, machine_state, cursor);
  endtask

  task automatic hold_l(input int n);
    logic [3:0] old_s;
    int first;
    int pulses;
    old_s  = m_state;
    first  = -1;
    pulses = 0;
    btnL   = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (machine_state != old_s && first < 0) first = i;
      if (state_changed) pulses++;
    end
    if (old_s != 4'd0) begin
      check("esc_time", first, DC + 2 + HC);
      check("esc_pulses", pulses, 1);
      m_state = 4'd0;
    end else begin
      check("home_hold_time", first, -1);
      check("home_hold_pulses", pulses, 0);
    end
    check("hold_state", machine_state, m_state);
    check("hold_cursor", cursor, m_cursor);
    btnL = 1'b0;
    repeat (DC + 4) tick();
    $display("hold L %0d cycles -> state=%0d cursor=%0d", n, machine_state, cursor);
  endtask

  initial begin
    int first;
    int changes;
    int pulses;
    logic [2:0] prev_c;
    int r;

    do_reset();
    for (int i = 0; i < 3; i++) press(5'b00100);
    check("d3_cursor", cursor, 3);

    // Bouncing U must not be accepted; the following clean hold gives one step.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      btnU = ((i / 2) % 2) == 0;
      tick();
    end
    btnU    = 1'b1;
    first   = -1;
    changes = 0;
    prev_c  = cursor;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cursor != prev_c) begin
        changes++;
        if (first < 0) first = i;
      end
      prev_c = cursor;
    end
    check("bounce_changes", changes, 1);
    check("bounce_time", first, DC + 3);
    check("bounce_cursor", cursor, 7);
    m_cursor = 3'd7;
    btnU = 1'b0;
    repeat (DC + 4) tick();
    $display("bounce U -> cursor=%0d", cursor);

    press(5'b00001);
    check("enter_10", machine_state, 10);
    press(5'b10000);
    check("wrap_to_1", machine_state, 1);
    check("wrap_cursor", cursor, 0);
    for (int i = 0; i < 3; i++) press(5'b10000);
    check("at_5", machine_state, 5);
    hold_l(40);
    press(5'b00001);
    check("reenter_5", machine_state, 5);
    hold_l(40);
    press(5'b00010);
    press(5'b00101);
    check("cd_state", machine_state, 4);
    check("cd_cursor", cursor, 2);

    // Invalid code recovery
    force dut.r_state = 4'd7;
    #1;
    release dut.r_state;
    tick();
    check("recover_state", machine_state, 0);
    check("recover_cursor", cursor, 0);
    check("recover_changed", state_changed, 1);
    m_state  = 4'd0;
    m_cursor = 3'd0;
    $display("invalid code 7 -> state=%0d cursor=%0d", machine_state, cursor);

    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    press(5'b00001);
        2, 3:    press(5'b00010);
        4, 5:    press(5'b00100);
        6, 7:    press(5'b10000);
        8:       press(5'($urandom_range(1, 31)));
        default: hold_l(40);
      endcase
    end

    // Reset in the middle of a hold: progress is lost and held D re-debounces as a press.
    if (m_state == 4'd0) press(5'b00001);
    btnL = 1'b1;
    btnD = 1'b1;
    repeat (DC + 2 + HC / 2) tick();
    rst_n = 1'b0;
    tick();
    tick();
    check("mid_rst_state", machine_state, 0);
    check("mid_rst_cursor", cursor, 0);
    check("mid_rst_changed", state_changed, 0);
    rst_n   = 1'b1;
    changes = 0;
    pulses  = 0;
    for (int i = 0; i < 3 * HC; i++) begin
      tick();
      if (machine_state != 4'd0) changes++;
      if (state_changed) pulses++;
    end
    check("post_rst_state_moves", changes, 0);
    check("post_rst_pulses", pulses, 0);
    check("post_rst_cursor", cursor, 1);
    set_btns(5'b0);
    repeat (DC + 4) tick();
    $display("reset mid-hold -> state=%0d cursor=%0d", machine_state, cursor);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
